// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if: MEM-side port and data-memory write/read port of the store buffer.
interface dm_store_buffer_if;
    logic        MemRead_IN;
    logic        MemWrite_IN;
    logic [31:0] data_address_IN;
    logic [31:0] data_write_IN;
    logic [1:0]  data_write_size_IN;
    logic [31:0] data_read_OUT;
    logic        STALL_OUT;
    logic        Buffer_Empty_OUT;
    logic [31:0] mem_raddr_OUT;
    logic [31:0] mem_rdata_IN;
    logic [31:0] mem_waddr_OUT;
    logic [31:0] mem_wdata_OUT;
    logic [3:0]  mem_byte_en_OUT;
    logic        mem_wreq_OUT;
    logic        mem_wack_IN;

    modport slave (
        input  MemRead_IN, MemWrite_IN, data_address_IN, data_write_IN, data_write_size_IN,
               mem_rdata_IN, mem_wack_IN,
        output data_read_OUT, STALL_OUT, Buffer_Empty_OUT, mem_raddr_OUT,
               mem_waddr_OUT, mem_wdata_OUT, mem_byte_en_OUT, mem_wreq_OUT
    );

    modport master (
        output MemRead_IN, MemWrite_IN, data_address_IN, data_write_IN, data_write_size_IN,
               mem_rdata_IN, mem_wack_IN,
        input  data_read_OUT, STALL_OUT, Buffer_Empty_OUT, mem_raddr_OUT,
               mem_waddr_OUT, mem_wdata_OUT, mem_byte_en_OUT, mem_wreq_OUT
    );
endinterface

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO between MEM and data memory with coherent loads.
// STORE_FWD_EN defined: loads merge pending bytes; undefined: loads hitting a pending word stall.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input logic             CLK,
    input logic             RESET,
    dm_store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, enq, deq;
    logic [2:0]    n;
    logic [1:0]    o;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic [AW-1:0] age_idx [DEPTH];
    logic [DEPTH-1:0] age_hit;
    logic [31:0]   rd_merge;

    // Field MSB is first moved to offset 0, then shifted down to offset o; overflow bytes fall off.
    always_comb begin
        n       = (bus.data_write_size_IN == 2'd0) ? 3'd4 : {1'b0, bus.data_write_size_IN};
        o       = bus.data_address_IN[1:0];
        st_data = (bus.data_write_IN << {3'd4 - n, 3'b000}) >> {o, 3'b000};
        st_be   = (4'b1111 << (3'd4 - n)) >> o;
    end

    always_comb begin
        full     = count_q == CW'(DEPTH);
        enq      = bus.MemWrite_IN & ~full & ~RESET;
        deq      = bus.mem_wreq_OUT & bus.mem_wack_IN;
        rd_ptr_d = rd_ptr_q + AW'(deq);
        wr_ptr_d = wr_ptr_q + AW'(enq);
        count_d  = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= bus.data_address_IN[31:2];
            data_q[wr_ptr_q] <= st_data;
            be_q[wr_ptr_q]   <= st_be;
        end
    end

    // age_hit[k]: k-th oldest entry is valid and targets the load's word
    always_comb begin
        age_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx[k] = rd_ptr_q + AW'(k);
            age_hit[k] = (CW'(k) < count_q) && (addr_q[age_idx[k]] == bus.data_address_IN[31:2]);
        end
    end

`ifdef STORE_FWD_EN
    always_comb begin
        rd_merge = bus.mem_rdata_IN;
        for (int k = 0; k < DEPTH; k++)
            for (int b = 0; b < 4; b++)
                if (age_hit[k] && be_q[age_idx[k]][b])
                    rd_merge[8*b +: 8] = data_q[age_idx[k]][8*b +: 8];
    end
    assign bus.STALL_OUT = ~RESET & bus.MemWrite_IN & full;
`else
    assign rd_merge      = bus.mem_rdata_IN;
    assign bus.STALL_OUT = ~RESET & ((bus.MemWrite_IN & full) | (bus.MemRead_IN & |age_hit));
`endif

    assign bus.data_read_OUT    = rd_merge;
    assign bus.mem_raddr_OUT    = {bus.data_address_IN[31:2], 2'b00};
    assign bus.Buffer_Empty_OUT = count_q == '0;
    assign bus.mem_wreq_OUT     = count_q != '0;
    assign bus.mem_waddr_OUT    = {addr_q[rd_ptr_q], 2'b00};
    assign bus.mem_wdata_OUT    = data_q[rd_ptr_q];
    assign bus.mem_byte_en_OUT  = be_q[rd_ptr_q];
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed vector table plus full-buffer and reset sequences.
module tb_dm_store_buffer;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_store_buffer_if bus();
    dm_store_buffer #(.DEPTH(4)) dut (.CLK(clk), .RESET(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wd;
        logic [1:0]  sz;
        logic [31:0] rdata;
        logic        wack;
        logic        e_stall, e_empty, e_wreq;
        logic [31:0] e_waddr, e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rd, wr, input logic [31:0] addr, wd, input logic [1:0] sz,
                       input logic [31:0] rdata, input logic wack,
                       input logic e_stall, e_empty, e_wreq, input logic [31:0] e_waddr, e_wdata,
                       input logic [3:0] e_be, input logic [31:0] e_rd);
        vec_t v;
        v = '{rd, wr, addr, wd, sz, rdata, wack, e_stall, e_empty, e_wreq, e_waddr, e_wdata, e_be, e_rd};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rd, wr, input logic [31:0] addr, wd, input logic [1:0] sz,
                         input logic [31:0] rdata, input logic wack);
        bus.MemRead_IN         = rd;
        bus.MemWrite_IN        = wr;
        bus.data_address_IN    = addr;
        bus.data_write_IN      = wd;
        bus.data_write_size_IN = sz;
        bus.mem_rdata_IN       = rdata;
        bus.mem_wack_IN        = wack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // SW to 0x100, acked on the second offered cycle
        add(0,0,32'h0,32'h0,2'd0,32'h0,0,               0,1,0,32'h0,32'h0,4'h0,32'h0);
        add(0,1,32'h100,32'h11223344,2'd0,32'h0,0,      0,1,0,32'h0,32'h0,4'h0,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,0,               0,0,1,32'h100,32'h11223344,4'hF,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,1,               0,0,1,32'h100,32'h11223344,4'hF,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,0,               0,1,0,32'h0,32'h0,4'h0,32'h0);
        // SB 0xAB to 0x201, then LW 0x200 before and during the ack
        add(0,1,32'h201,32'hAB,2'd1,32'h0,0,            0,1,0,32'h0,32'h0,4'h0,32'h0);
        add(1,0,32'h200,32'h0,2'd0,32'h0,0,             !FWD,0,1,32'h200,32'h00AB0000,4'b0100,FWD ? 32'h00AB0000 : 32'h0);
        add(1,0,32'h200,32'h0,2'd0,32'h0,1,             !FWD,0,1,32'h200,32'h00AB0000,4'b0100,FWD ? 32'h00AB0000 : 32'h0);
        add(1,0,32'h200,32'h0,2'd0,32'h0,0,             0,1,0,32'h0,32'h0,4'h0,32'h0);
        // SH 0x1234 @0x302, SB 0x56 @0x303, LW 0x300 over 0xFFFFFFFF
        add(0,1,32'h302,32'h1234,2'd2,32'h0,0,          0,1,0,32'h0,32'h0,4'h0,32'h0);
        add(0,1,32'h303,32'h56,2'd1,32'h0,0,            0,0,1,32'h300,32'h00001234,4'b0011,32'h0);
        add(1,0,32'h300,32'h0,2'd0,32'hFFFFFFFF,0,      !FWD,0,1,32'h300,32'h00001234,4'b0011,FWD ? 32'hFFFF1256 : 32'hFFFFFFFF);
        add(0,0,32'h0,32'h0,2'd0,32'h0,1,               0,0,1,32'h300,32'h00001234,4'b0011,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,1,               0,0,1,32'h300,32'h00000056,4'b0001,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,0,               0,1,0,32'h0,32'h0,4'h0,32'h0);
        // Size 3 @ offset 1, size 2 @ offset 3 (enqueue while head is acked)
        add(0,1,32'h401,32'h00AABBCC,2'd3,32'h0,0,      0,1,0,32'h0,32'h0,4'h0,32'h0);
        add(0,1,32'h503,32'h00001234,2'd2,32'h0,1,      0,0,1,32'h400,32'h00AABBCC,4'b0111,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,1,               0,0,1,32'h500,32'h00000012,4'b0001,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,0,               0,1,0,32'h0,32'h0,4'h0,32'h0);
        // Load to a word with no pending store
        add(0,1,32'h700,32'hDEADBEEF,2'd0,32'h0,0,      0,1,0,32'h0,32'h0,4'h0,32'h0);
        add(1,0,32'h600,32'h0,2'd0,32'hCAFEF00D,0,      0,0,1,32'h700,32'hDEADBEEF,4'hF,32'hCAFEF00D);
        add(0,0,32'h0,32'h0,2'd0,32'h0,1,               0,0,1,32'h700,32'hDEADBEEF,4'hF,32'h0);
        add(0,0,32'h0,32'h0,2'd0,32'h0,0,               0,1,0,32'h0,32'h0,4'h0,32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].sz, tbl[i].rdata, tbl[i].wack);
            #1;
            chk($sformatf("r%0d.stall", i), 32'(bus.STALL_OUT), 32'(tbl[i].e_stall));
            chk($sformatf("r%0d.empty", i), 32'(bus.Buffer_Empty_OUT), 32'(tbl[i].e_empty));
            chk($sformatf("r%0d.wreq", i), 32'(bus.mem_wreq_OUT), 32'(tbl[i].e_wreq));
            if (tbl[i].e_wreq) begin
                chk($sformatf("r%0d.waddr", i), bus.mem_waddr_OUT, tbl[i].e_waddr);
                chk($sformatf("r%0d.wdata", i), bus.mem_wdata_OUT, tbl[i].e_wdata);
                chk($sformatf("r%0d.be", i), 32'(bus.mem_byte_en_OUT), 32'(tbl[i].e_be));
            end
            chk($sformatf("r%0d.rdata", i), bus.data_read_OUT, tbl[i].e_rd);
            chk($sformatf("r%0d.raddr", i), bus.mem_raddr_OUT, {tbl[i].addr[31:2], 2'b00});
            tick();
        end

        // Fill DEPTH=4, fifth store stalls until one ack frees a slot
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h1000 + 32'(4*i), 32'hA0 + 32'(i), 2'd0, 32'h0, 0);
            #1;
            chk($sformatf("fill%0d.stall", i), 32'(bus.STALL_OUT), 32'h0);
            tick();
        end
        drive(0, 1, 32'h1010, 32'hA4, 2'd0, 32'h0, 0);
        #1;
        chk("full.stall", 32'(bus.STALL_OUT), 32'h1);
        tick();
        drive(0, 1, 32'h1010, 32'hA4, 2'd0, 32'h0, 1);
        #1;
        chk("full_ack.stall", 32'(bus.STALL_OUT), 32'h1);
        chk("full_ack.waddr", bus.mem_waddr_OUT, 32'h1000);
        chk("full_ack.wdata", bus.mem_wdata_OUT, 32'hA0);
        tick();
        drive(0, 1, 32'h1010, 32'hA4, 2'd0, 32'h0, 0);
        #1;
        chk("after_ack.stall", 32'(bus.STALL_OUT), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'h0, 32'h0, 2'd0, 32'h0, 1);
            #1;
            chk($sformatf("drain%0d.wreq", i), 32'(bus.mem_wreq_OUT), 32'h1);
            chk($sformatf("drain%0d.waddr", i), bus.mem_waddr_OUT, 32'h1004 + 32'(4*i));
            chk($sformatf("drain%0d.wdata", i), bus.mem_wdata_OUT, 32'hA1 + 32'(i));
            tick();
        end
        drive(0, 0, 32'h0, 32'h0, 2'd0, 32'h0, 0);
        #1;
        chk("drained.empty", 32'(bus.Buffer_Empty_OUT), 32'h1);
        tick();

        // Reset with the buffer full and a request outstanding
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h2000, 32'h55 + 32'(i), 2'd0, 32'h0, 0);
            tick();
        end
        drive(0, 1, 32'h2000, 32'h99, 2'd0, 32'h0, 0);
        #1;
        chk("pre_rst.wreq", 32'(bus.mem_wreq_OUT), 32'h1);
        chk("pre_rst.stall", 32'(bus.STALL_OUT), 32'h1);
        rst = 1'b1;
        #1;
        chk("in_rst.stall", 32'(bus.STALL_OUT), 32'h0);
        tick();
        rst = 1'b0;
        drive(1, 0, 32'h2000, 32'h0, 2'd0, 32'h12345678, 0);
        #1;
        chk("post_rst.wreq", 32'(bus.mem_wreq_OUT), 32'h0);
        chk("post_rst.empty", 32'(bus.Buffer_Empty_OUT), 32'h1);
        chk("post_rst.stall", 32'(bus.STALL_OUT), 32'h0);
        chk("post_rst.rdata", bus.data_read_OUT, 32'h12345678);
        tick();
        #1;
        chk("post_rst2.empty", 32'(bus.Buffer_Empty_OUT), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
